// File: rtl/input_cmd_fifo.sv
// Player-command queue: UART keys and buttons into a circular FIFO.
// Optional auto-repeat of held buttons under INPUT_CMD_AUTOREPEAT_EN.
package enum_type;
  typedef enum logic [2:0] {
    NONE, LEFT, RIGHT, DOWN,
    DROP, HOLD, ROTATE, ROTATE_REV
  } state_type;
endpackage

module input_cmd_fifo
  import enum_type::*;
#(
  parameter int DEPTH         = 16,
  parameter int REPEAT_DELAY  = 30_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic [3:0]                 btn,
  input  logic                       cmd_pop,
  output logic                       cmd_valid,
  output state_type                  cmd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       ovf_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_type       mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      prev_q;
  logic [3:0]      win, rep;
  state_type       key_cmd, btn_cmd, enq_cmd;
  logic            key_ok, enq, do_pop;
  logic            do_push, drop;

  always_comb begin
    key_ok  = 1'b1;
    key_cmd = NONE;
    case (rx_byte)
      "A", "a":      key_cmd = LEFT;
      "D", "d":      key_cmd = RIGHT;
      "W", "w":      key_cmd = DOWN;
      "S", "s", " ": key_cmd = DROP;
      "C", "c":      key_cmd = HOLD;
      "X", "x":      key_cmd = ROTATE;
      "Z", "z":      key_cmd = ROTATE_REV;
      default:       key_ok  = 1'b0;
    endcase
  end

  always_comb begin
    win     = 4'b0000;
    btn_cmd = NONE;
    priority casez (pend_q)
      4'b???1: begin win = 4'b0001; btn_cmd = RIGHT;  end
      4'b??10: begin win = 4'b0010; btn_cmd = DOWN;   end
      4'b?100: begin win = 4'b0100; btn_cmd = LEFT;   end
      4'b1000: begin win = 4'b1000; btn_cmd = ROTATE; end
      default: ;
    endcase
  end

`ifdef INPUT_CMD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX+1);

  logic [RW-1:0] rcnt_q [3];
  logic [RW-1:0] rcnt_d [3];
  logic [2:0]    rfir_q, rfir_d;
  logic [RW-1:0] lim;

  // counter runs only while held; first fire after DELAY, then every PERIOD
  always_comb begin
    rep    = 4'b0000;
    rfir_d = 3'b000;
    lim    = '0;
    for (int i = 0; i < 3; i++) begin
      rcnt_d[i] = '0;
      lim = rfir_q[i] ? RW'(REPEAT_PERIOD-1) : RW'(REPEAT_DELAY-1);
      if (btn[i] && prev_q[i]) begin
        if (rcnt_q[i] == lim) begin
          rep[i]    = 1'b1;
          rfir_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
          rfir_d[i] = rfir_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rfir_q <= '0;
      for (int i = 0; i < 3; i++) rcnt_q[i] <= '0;
    end else begin
      rfir_q <= rfir_d;
      for (int i = 0; i < 3; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep = 4'b0000;
`endif

  always_comb begin
    enq     = (rx_valid && key_ok) || (pend_q != 4'b0000);
    enq_cmd = (rx_valid && key_ok) ? key_cmd : btn_cmd;
    do_pop  = cmd_pop && (cnt_q != '0);
    drop    = enq && (cnt_q == CW'(DEPTH)) && !do_pop;
    do_push = enq && !drop;
    pend_d  = pend_q | (btn & ~prev_q) | rep;
    if (!(rx_valid && key_ok))
      pend_d = (pend_q & ~win) | (btn & ~prev_q) | rep;
    rd_d = rd_q;
    if (do_pop)
      rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
    wr_d = wr_q;
    if (do_push)
      wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      pend_q <= pend_d;
      prev_q <= btn;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && reset_n) mem_q[wr_q] <= enq_cmd;
  end

  assign cmd_valid = (cnt_q != '0);
  assign cmd       = cmd_valid ? mem_q[rd_q] : NONE;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_input_cmd_fifo.sv
// Bench for input_cmd_fifo: directed table plus randomized run
// against a queue-based model; repeat test under INPUT_CMD_AUTOREPEAT_EN.
module tb_input_cmd_fifo;
  import enum_type::*;

  localparam int DEPTH = 4;
  localparam int RD    = 10;
  localparam int RP    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [3:0] btn = 4'h0;
  logic       cmd_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       cmd_valid;
  state_type  cmd;
  logic [2:0] count;
  logic       overflow;

  int vecs = 0;
  int errs = 0;

  input_cmd_fifo #(
    .DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .btn(btn), .cmd_pop(cmd_pop),
    .cmd_valid(cmd_valid), .cmd(cmd), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // reference model
  state_type mq[$];
  logic [3:0] mpend, mprev;
  logic       movf;
  int         mheld [4];

  function automatic state_type keymap(input logic [7:0] b,
                                       output bit ok);
    ok = 1'b1;
    case (b)
      8'h41, 8'h61: return LEFT;
      8'h44, 8'h64: return RIGHT;
      8'h57, 8'h77: return DOWN;
      8'h53, 8'h73, 8'h20: return DROP;
      8'h43, 8'h63: return HOLD;
      8'h58, 8'h78: return ROTATE;
      8'h5A, 8'h7A: return ROTATE_REV;
      default: begin ok = 1'b0; return NONE; end
    endcase
  endfunction

  function automatic state_type bmap(input int i);
    case (i)
      0: return RIGHT;
      1: return DOWN;
      2: return LEFT;
      default: return ROTATE;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    mpend = '0;
    mprev = '0;
    movf  = 1'b0;
    for (int i = 0; i < 4; i++) mheld[i] = 0;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] rb,
                            input logic [3:0] b, input logic pop,
                            input logic clr);
    state_type e;
    bit ok, enq, popok, drp;
    int win;
    win = -1;
    enq = 1'b0;
    e = keymap(rb, ok);
    if (rv && ok) enq = 1'b1;
    else
      for (int i = 0; i < 4; i++)
        if (mpend[i] && win < 0) begin
          win = i; enq = 1'b1; e = bmap(i);
        end
    if (win >= 0) mpend[win] = 1'b0;
    popok = pop && (mq.size() > 0);
    drp = enq && (mq.size() == DEPTH) && !popok;
    if (popok) void'(mq.pop_front());
    if (enq && !drp) mq.push_back(e);
    if (drp) movf = 1'b1;
    else if (clr) movf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] && !mprev[i]) begin
        mpend[i] = 1'b1;
        mheld[i] = 0;
      end else if (b[i]) begin
        mheld[i]++;
`ifdef INPUT_CMD_AUTOREPEAT_EN
        if (i < 3 && mheld[i] >= RD && (mheld[i] - RD) % RP == 0)
          mpend[i] = 1'b1;
`endif
      end else mheld[i] = 0;
    end
    mprev = b;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic rv, input logic [7:0] rb,
                       input logic [3:0] b, input logic pop,
                       input logic clr);
    rx_valid = rv; rx_byte = rb; btn = b;
    cmd_pop = pop; ovf_clr = clr;
    model_step(rv, rb, b, pop, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, int'(cmd_valid), int'(mq.size() != 0));
    chk({tag, ".cmd"}, int'(cmd),
        mq.size() != 0 ? int'(mq[0]) : int'(NONE));
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".ovf"}, int'(overflow), int'(movf));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    btn = 4'h0; cmd_pop = 1'b0; ovf_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       rv;
    logic [7:0] rb;
    logic [3:0] b;
    logic       pop;
    logic       clr;
    logic       ev;
    state_type  ec;
    int         en;
    logic       eo;
  } vec_t;

  vec_t tbl [29];
  logic [7:0] bytes [12];

  initial begin
    bytes = '{8'h61, 8'h44, 8'h77, 8'h53, 8'h20, 8'h63,
              8'h78, 8'h5A, 8'h71, 8'h00, 8'hFF, 8'h31};
    tbl = '{
      '{1, 8'h61, 4'h0, 0, 0, 1, LEFT,   1, 0},
      '{0, 8'h00, 4'h0, 1, 0, 0, NONE,   0, 0},
      '{1, 8'h78, 4'h5, 0, 0, 1, ROTATE, 1, 0},
      '{0, 8'h00, 4'h5, 0, 0, 1, ROTATE, 2, 0},
      '{0, 8'h00, 4'h5, 0, 0, 1, ROTATE, 3, 0},
      '{0, 8'h00, 4'h0, 1, 0, 1, RIGHT,  2, 0},
      '{0, 8'h00, 4'h0, 1, 0, 1, LEFT,   1, 0},
      '{0, 8'h00, 4'h0, 1, 0, 0, NONE,   0, 0},
      '{1, 8'h63, 4'h0, 1, 0, 1, HOLD,   1, 0},
      '{1, 8'h71, 4'h0, 0, 0, 1, HOLD,   1, 0},
      '{1, 8'h00, 4'h0, 0, 0, 1, HOLD,   1, 0},
      '{0, 8'h00, 4'h0, 1, 0, 0, NONE,   0, 0},
      '{1, 8'h64, 4'h0, 0, 0, 1, RIGHT,  1, 0},
      '{1, 8'h64, 4'h0, 0, 0, 1, RIGHT,  2, 0},
      '{1, 8'h64, 4'h0, 0, 0, 1, RIGHT,  3, 0},
      '{1, 8'h64, 4'h0, 0, 0, 1, RIGHT,  4, 0},
      '{1, 8'h64, 4'h0, 0, 0, 1, RIGHT,  4, 1},
      '{1, 8'h73, 4'h0, 1, 1, 1, RIGHT,  4, 0},
      '{0, 8'h00, 4'h0, 1, 0, 1, RIGHT,  3, 0},
      '{0, 8'h00, 4'h0, 1, 0, 1, RIGHT,  2, 0},
      '{0, 8'h00, 4'h0, 1, 0, 1, DROP,   1, 0},
      '{0, 8'h00, 4'h0, 1, 0, 0, NONE,   0, 0},
      '{1, 8'h57, 4'h0, 0, 0, 1, DOWN,   1, 0},
      '{1, 8'h57, 4'h0, 0, 0, 1, DOWN,   2, 0},
      '{1, 8'h57, 4'h0, 0, 0, 1, DOWN,   3, 0},
      '{1, 8'h57, 4'h0, 0, 0, 1, DOWN,   4, 0},
      '{1, 8'h57, 4'h0, 0, 1, 1, DOWN,   4, 1},
      '{0, 8'h00, 4'h0, 0, 1, 1, DOWN,   4, 0},
      '{1, 8'h20, 4'h0, 1, 0, 1, DOWN,   4, 0}
    };

    do_reset();
    chk("rst.valid", int'(cmd_valid), 0);
    chk("rst.cmd", int'(cmd), int'(NONE));
    chk("rst.count", int'(count), 0);
    chk("rst.ovf", int'(overflow), 0);

    foreach (tbl[k]) begin
      apply(tbl[k].rv, tbl[k].rb, tbl[k].b, tbl[k].pop, tbl[k].clr);
      chk($sformatf("t%0d.valid", k), int'(cmd_valid), int'(tbl[k].ev));
      chk($sformatf("t%0d.cmd", k), int'(cmd), int'(tbl[k].ec));
      chk($sformatf("t%0d.count", k), int'(count), tbl[k].en);
      chk($sformatf("t%0d.ovf", k), int'(overflow), int'(tbl[k].eo));
    end

    // tail of the full FIFO must be the DROP from the space byte
    for (int k = 0; k < 4; k++) begin
      apply(0, 8'h00, 4'h0, 1, 0);
    end
    chk("tail.count", int'(count), 0);

`ifdef INPUT_CMD_AUTOREPEAT_EN
    do_reset();
    for (int k = 0; k < 22; k++) apply(0, 8'h00, 4'h4, 0, 0);
    for (int k = 0; k < 4; k++) apply(0, 8'h00, 4'h0, 0, 0);
    chk("rep.count", int'(count), 4);
    chk("rep.ovf", int'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      chk("rep.cmd", int'(cmd), int'(LEFT));
      apply(0, 8'h00, 4'h0, 1, 0);
    end
    for (int k = 0; k < 22; k++) apply(0, 8'h00, 4'h8, 0, 0);
    for (int k = 0; k < 4; k++) apply(0, 8'h00, 4'h0, 0, 0);
    chk("rot.count", int'(count), 1);
    chk("rot.cmd", int'(cmd), int'(ROTATE));
`endif

    do_reset();
    begin
      logic [3:0] b;
      b = 4'h0;
      for (int k = 0; k < 3000; k++) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
        apply($urandom_range(0, 9) < 3,
              bytes[$urandom_range(0, 11)], b,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 19) == 0);
        chk_model("rnd");
      end
    end

    do_reset();
    chk_model("midrst");
    apply(0, 8'h00, 4'h0, 0, 0);
    chk_model("midrst2");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
